// File: rtl/conv_window_stream.sv
// Weight unpacker and K x K sliding-window generator for the BNN convolution array.
// One byte stream carries either packed kernel bits (mode=1) or image pixels (mode=0).
module conv_window_stream #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_W  = 28,
  parameter int unsigned IMG_H  = 28,
  parameter int unsigned K      = 5,
  parameter int unsigned NUM_K  = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       mode,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  output logic [NUM_K*K*K-1:0]       weights,
  output logic                       weights_done,
  output logic [K*K*DATA_W-1:0]      win_data,
  output logic                       win_valid,
  input  logic                       win_ready,
  output logic [$clog2(IMG_H)-1:0]   win_row,
  output logic [$clog2(IMG_W)-1:0]   win_col,
  output logic                       frame_done
);

  localparam int unsigned NW     = NUM_K * K * K;
  localparam int unsigned NBEATS = (NW + DATA_W - 1) / DATA_W;
  localparam int unsigned BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int unsigned SHW    = $clog2(NBEATS * DATA_W) + 1;
  localparam int unsigned L      = (K - 1) * IMG_W + K;
  localparam int unsigned XW     = $clog2(IMG_W);
  localparam int unsigned YW     = $clog2(IMG_H);
  localparam int unsigned WW     = K * K * DATA_W;

  logic              acc_w, acc_p;
  logic              last_beat, win_hit, last_x, last_y;
  logic [BW-1:0]     w_idx;
  logic [SHW-1:0]    w_sh;
  logic [NW-1:0]     w_mask, w_beat;
  logic [L*DATA_W-1:0] sr, sr_nxt;
  logic [WW-1:0]     win_nxt;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;

  // Pixel beats stall only while a window is waiting for the consumer
  always_comb begin
    in_ready = mode || !(win_valid && !win_ready);
    acc_w    = in_valid && in_ready && mode;
    acc_p    = in_valid && in_ready && !mode;
  end

  // Beat placement; bits shifted past the top of the weight vector fall off naturally
  always_comb begin
    last_beat = (w_idx == BW'(NBEATS - 1));
    w_sh      = SHW'(w_idx) * SHW'(DATA_W);
    w_mask    = NW'({DATA_W{1'b1}}) << w_sh;
    w_beat    = NW'(in_data) << w_sh;
  end

  // Window taps are taken from the post-shift register so the completing pixel is included
  always_comb begin
    sr_nxt  = {sr[(L-1)*DATA_W-1:0], in_data};
    win_nxt = '0;
    for (int unsigned r = 0; r < K; r++) begin
      for (int unsigned c = 0; c < K; c++) begin
        win_nxt[(r*K+c)*DATA_W +: DATA_W] =
          sr_nxt[((K-1-r)*IMG_W + (K-1-c))*DATA_W +: DATA_W];
      end
    end
    win_hit = (y >= YW'(K - 1)) && (x >= XW'(K - 1));
    last_x  = (x == XW'(IMG_W - 1));
    last_y  = (y == YW'(IMG_H - 1));
  end

  // Weight loader
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weights      <= '0;
      weights_done <= 1'b0;
      w_idx        <= '0;
    end else if (acc_w) begin
      weights      <= (weights & ~w_mask) | w_beat;
      weights_done <= last_beat;
      w_idx        <= last_beat ? '0 : w_idx + BW'(1);
    end
  end

  // Pixel position; a weight beat restarts the frame at (0,0)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (acc_w) begin
      x <= '0;
      y <= '0;
    end else if (acc_p) begin
      if (last_x) begin
        x <= '0;
        y <= last_y ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (acc_p) begin
      sr <= sr_nxt;
    end
  end

  // Output window register; a newly registered window takes priority over the handshake clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid  <= 1'b0;
      win_data   <= '0;
      win_row    <= '0;
      win_col    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= acc_p && last_x && last_y;
      if (acc_p && win_hit) begin
        win_valid <= 1'b1;
        win_data  <= win_nxt;
        win_row   <= y - YW'(K - 1);
        win_col   <= x - XW'(K - 1);
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_stream.sv
// Directed bench for conv_window_stream: weight load, window placement, backpressure,
// two back-to-back frames against a window model, and mid-frame reset.
module tb_conv_window_stream;

  localparam int unsigned DW = 8;
  localparam int unsigned IW = 28;
  localparam int unsigned IH = 28;
  localparam int unsigned KK = 5;
  localparam int unsigned NK = 12;
  localparam int unsigned NW = NK * KK * KK;
  localparam int unsigned WW = KK * KK * DW;
  localparam int unsigned OW = IW - KK + 1;
  localparam int unsigned NWIN = OW * (IH - KK + 1);

  logic          clk;
  logic          rst_n;
  logic          mode;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [NW-1:0] weights;
  logic          weights_done;
  logic [WW-1:0] win_data;
  logic          win_valid;
  logic          win_ready;
  logic [4:0]    win_row;
  logic [4:0]    win_col;
  logic          frame_done;

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;
  bit rand_en = 1'b0;
  int hs_total = 0;
  int exp_idx = 0;

  conv_window_stream #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .K(KK), .NUM_K(NK)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .weights(weights), .weights_done(weights_done),
    .win_data(win_data), .win_valid(win_valid), .win_ready(win_ready),
    .win_row(win_row), .win_col(win_col), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [NW-1:0] got, input logic [NW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pix(input int y, input int x);
    return DW'((y * IW + x) & 255);
  endfunction

  function automatic logic [WW-1:0] model_win(input int wr, input int wc);
    logic [WW-1:0] w;
    w = '0;
    for (int r = 0; r < KK; r++)
      for (int c = 0; c < KK; c++)
        w[(r*KK+c)*DW +: DW] = pix(wr + r, wc + c);
    return w;
  endfunction

  // One accepted beat; returns at posedge+1 of the accepting edge
  task automatic push(input logic m, input logic [DW-1:0] d);
    int n;
    n = 0;
    mode = m;
    in_data = d;
    in_valid = 1'b1;
    if (rand_en) win_ready = 1'($urandom_range(0, 1));
    #1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      if (rand_en) win_ready = 1'b1;
      #1;
      n++;
    end
    if (!in_ready) check("push_timeout", NW'(in_ready), NW'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Window scoreboard for the full-frame phase
  always @(negedge clk) begin
    if (mon_en) begin
      if (win_valid && win_ready) begin
        check("sb_row", NW'(win_row), NW'(exp_idx / OW));
        check("sb_col", NW'(win_col), NW'(exp_idx % OW));
        check("sb_data", NW'(win_data), NW'(model_win(exp_idx / OW, exp_idx % OW)));
        exp_idx = (exp_idx + 1) % NWIN;
        hs_total++;
      end
      if (frame_done) begin
        check("fd_valid", NW'(win_valid), NW'(1));
        check("fd_row", NW'(win_row), NW'(IH - KK));
        check("fd_col", NW'(win_col), NW'(IW - KK));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NW-1:0] exp_w;
    rst_n = 1'b0; mode = 1'b0; in_valid = 1'b0; in_data = '0; win_ready = 1'b1;
    #12;
    check("rst_weights", weights, '0);
    check("rst_wdone", NW'(weights_done), NW'(0));
    check("rst_win_data", NW'(win_data), NW'(0));
    check("rst_win_valid", NW'(win_valid), NW'(0));
    check("rst_win_row", NW'(win_row), NW'(0));
    check("rst_win_col", NW'(win_col), NW'(0));
    check("rst_frame_done", NW'(frame_done), NW'(0));
    check("rst_in_ready", NW'(in_ready), NW'(1));
    @(negedge clk) rst_n = 1'b1;

    // Weight load: all ones, then a reload leaving only the 4 valid bits of the last beat
    for (int b = 0; b < 38; b++) begin
      push(1'b1, 8'hFF);
      if (b == 36) check("wdone_early", NW'(weights_done), NW'(0));
    end
    check("w_all_ones", weights, {NW{1'b1}});
    check("wdone_set", NW'(weights_done), NW'(1));
    for (int b = 0; b < 37; b++) begin
      push(1'b1, 8'h00);
      if (b == 0) check("wdone_clr", NW'(weights_done), NW'(0));
    end
    check("wdone_b37", NW'(weights_done), NW'(0));
    push(1'b1, 8'hAB);
    exp_w = '0;
    exp_w[299:296] = 4'hB;
    check("w_last_beat", weights, exp_w);
    check("wdone_b38", NW'(weights_done), NW'(1));

    // First window and row boundary
    for (int p = 0; p < 140; p++) begin
      push(1'b0, pix(p / IW, p % IW));
      if (p == 115) check("no_win_early", NW'(win_valid), NW'(0));
      if (p == 116) begin
        check("first_valid", NW'(win_valid), NW'(1));
        check("first_row", NW'(win_row), NW'(0));
        check("first_col", NW'(win_col), NW'(0));
        check("first_e0", NW'(win_data[0 +: DW]), NW'(0));
        check("first_e24", NW'(win_data[24*DW +: DW]), NW'(116));
      end
    end
    for (int x = 0; x < 4; x++) begin
      push(1'b0, pix(5, x));
      check("row_gap", NW'(win_valid), NW'(0));
    end
    push(1'b0, pix(5, 4));
    check("r1_valid", NW'(win_valid), NW'(1));
    check("r1_row", NW'(win_row), NW'(1));
    check("r1_col", NW'(win_col), NW'(0));
    check("r1_e0", NW'(win_data[0 +: DW]), NW'(28));
    check("r1_e24", NW'(win_data[24*DW +: DW]), NW'(144));
    check("r1_data", NW'(win_data), NW'(model_win(1, 0)));

    // Backpressure with a weight beat slipped in during the stall
    win_ready = 1'b0; mode = 1'b0; in_valid = 1'b1; in_data = pix(5, 5);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_in_ready", NW'(in_ready), NW'(0));
      check("bp_valid", NW'(win_valid), NW'(1));
      check("bp_data", NW'(win_data), NW'(model_win(1, 0)));
      check("bp_row", NW'(win_row), NW'(1));
      check("bp_col", NW'(win_col), NW'(0));
    end
    in_valid = 1'b0;
    push(1'b1, 8'h5A);
    exp_w[7:0] = 8'h5A;
    check("bp_w_accept", weights, exp_w);
    check("bp_wdone_clr", NW'(weights_done), NW'(0));
    check("bp_hold_data", NW'(win_data), NW'(model_win(1, 0)));
    check("bp_hold_valid", NW'(win_valid), NW'(1));
    win_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", NW'(win_valid), NW'(0));

    // Two back-to-back frames, random consumer stalls, position restarted by the weight beat
    exp_idx = 0; hs_total = 0; mon_en = 1'b1; rand_en = 1'b1;
    for (int f = 0; f < 2; f++)
      for (int y = 0; y < IH; y++)
        for (int x = 0; x < IW; x++) begin
          push(1'b0, pix(y, x));
          if (y == IH - 1 && x == IW - 1) check("frame_done", NW'(frame_done), NW'(1));
          else if (y == IH - 1 && x == IW - 2) check("frame_done_early", NW'(frame_done), NW'(0));
        end
    rand_en = 1'b0; win_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mon_en = 1'b0;
    check("win_total", NW'(hs_total), NW'(2 * NWIN));
    check("drain_valid", NW'(win_valid), NW'(0));
    check("fd_cleared", NW'(frame_done), NW'(0));

    // Mid-frame reset
    for (int p = 0; p < 300; p++) push(1'b0, pix(p / IW, p % IW));
    rst_n = 1'b0;
    #1;
    check("mr_weights", weights, '0);
    check("mr_wdone", NW'(weights_done), NW'(0));
    check("mr_win_data", NW'(win_data), NW'(0));
    check("mr_win_valid", NW'(win_valid), NW'(0));
    check("mr_row", NW'(win_row), NW'(0));
    check("mr_col", NW'(win_col), NW'(0));
    check("mr_frame_done", NW'(frame_done), NW'(0));
    @(negedge clk) rst_n = 1'b1;
    for (int p = 0; p < 117; p++) begin
      push(1'b0, pix(p / IW, p % IW));
      if (p == 115) check("mr_no_win", NW'(win_valid), NW'(0));
    end
    check("mr_first_valid", NW'(win_valid), NW'(1));
    check("mr_first_row", NW'(win_row), NW'(0));
    check("mr_first_col", NW'(win_col), NW'(0));
    check("mr_first_data", NW'(win_data), NW'(model_win(0, 0)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
